mni_cmd_regs: RTL

MNI_CMD_REGS -- requirements
Module: mni_cmd_regs

---
 rtl/mni_cmd_regs_if.sv | 33 +++
 rtl/mni_cmd_regs.sv | 110 +++++++++++
 2 files changed

// File: rtl/mni_cmd_regs_if.sv
// Host register bus and DMA op handshake of the NI command block.
// Host side drives i_* strobes, block drives o_* results.
interface mni_cmd_regs_if #(
  parameter int CH_BITS = 2,
  parameter int WD_BITS = 3
);
  logic               i_reg_write;
  logic               i_reg_sel_status;
  logic [CH_BITS-1:0] i_reg_ch;
  logic [WD_BITS-1:0] i_reg_wd;
  logic [1:0]         i_reg_ben;
  logic [15:0]        i_reg_wdata;
  logic [15:0]        o_rd_data;
  logic               o_op_valid;
  logic [CH_BITS-1:0] o_op_ch;
  logic               i_op_ready;
  logic               i_op_done;
  logic [CH_BITS-1:0] i_op_done_ch;

  modport master (
    output i_reg_write, i_reg_sel_status, i_reg_ch,
    output i_reg_wd, i_reg_ben, i_reg_wdata,
    output i_op_ready, i_op_done, i_op_done_ch,
    input  o_rd_data, o_op_valid, o_op_ch
  );

  modport slave (
    input  i_reg_write, i_reg_sel_status, i_reg_ch,
    input  i_reg_wd, i_reg_ben, i_reg_wdata,
    input  i_op_ready, i_op_done, i_op_done_ch,
    output o_rd_data, o_op_valid, o_op_ch
  );
endinterface

// File: rtl/mni_cmd_regs.sv
// Per-channel command registers, doorbell queue and drop counter.
// Ports: clk_ni, rst_ni (sync, active-high), bus (slave modport).
module mni_cmd_regs #(
  parameter int CH_BITS = 2,
  parameter int WD_BITS = 3,
  parameter int Q_BITS  = 2
) (
  input  logic          clk_ni,
  input  logic          rst_ni,
  mni_cmd_regs_if.slave bus
);
  localparam int NCH = 1 << CH_BITS;
  localparam int NW  = 1 << WD_BITS;
  localparam int QD  = 1 << Q_BITS;
  localparam int AW  = CH_BITS + WD_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUEUED = 2'd1,
    ACTIVE = 2'd2
  } ch_st_e;

  ch_st_e             st_q [NCH];
  ch_st_e             st_d [NCH];
  logic [15:0]        mem  [NCH*NW];
  logic [CH_BITS-1:0] fifo [QD];
  logic [Q_BITS-1:0]  rd_ptr;
  logic [Q_BITS-1:0]  wr_ptr;
  logic [Q_BITS:0]    cnt;
  logic [7:0]         drop_cnt;

  logic [AW-1:0] addr;
  logic          ch_wr;
  logic          ch_idle;
  logic          wr_ok;
  logic          dbell;
  logic          full;
  logic          push;
  logic          pop;
  logic          drop;
  logic          clr;
  logic [15:0]   busy;
  logic [4:0]    occ;

  assign addr    = {bus.i_reg_ch, bus.i_reg_wd};
  assign ch_wr   = bus.i_reg_write & ~bus.i_reg_sel_status & ~rst_ni;
  assign ch_idle = st_q[bus.i_reg_ch] == IDLE;
  assign wr_ok   = ch_wr & ch_idle;
  assign dbell   = wr_ok & (bus.i_reg_wd == '0) & bus.i_reg_ben[0];
  assign full    = cnt == (Q_BITS+1)'(QD);
  assign push    = dbell & ~full;
  assign pop     = bus.o_op_valid & bus.i_op_ready;
  // A doorbell that finds the queue full still writes RAM but is counted.
  assign drop    = ch_wr & (~ch_idle | (dbell & full));
  assign clr     = bus.i_reg_write & bus.i_reg_sel_status
                 & bus.i_reg_ben[0] & ~rst_ni;

  assign bus.o_op_valid = cnt != '0;
  assign bus.o_op_ch    = bus.o_op_valid ? fifo[rd_ptr] : '0;

  always_ff @(posedge clk_ni) begin
    if (wr_ok) begin
      if (bus.i_reg_ben[0]) mem[addr][7:0]  <= bus.i_reg_wdata[7:0];
      if (bus.i_reg_ben[1]) mem[addr][15:8] <= bus.i_reg_wdata[15:8];
    end
    if (push) fifo[wr_ptr] <= bus.i_reg_ch;
  end

  always_ff @(posedge clk_ni) begin
    if (rst_ni) begin
      for (int c = 0; c < NCH; c++) st_q[c] <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
      drop_cnt <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) st_q[c] <= st_d[c];
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (clr)                       drop_cnt <= '0;
      else if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Push needs IDLE, pop needs QUEUED, done needs ACTIVE: never overlap.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      st_d[c] = st_q[c];
      if (push && bus.i_reg_ch == CH_BITS'(c))
        st_d[c] = QUEUED;
      if (pop && bus.o_op_ch == CH_BITS'(c))
        st_d[c] = ACTIVE;
      if (bus.i_op_done && bus.i_op_done_ch == CH_BITS'(c)
          && st_q[c] == ACTIVE)
        st_d[c] = IDLE;
    end
  end

  always_comb begin
    busy = '0;
    for (int c = 0; c < NCH; c++) busy[c] = st_q[c] != IDLE;
    occ = 5'(cnt);
    if (bus.i_reg_sel_status)
      bus.o_rd_data = bus.i_reg_wd[0] ? {drop_cnt, 3'b000, occ} : busy;
    else
      bus.o_rd_data = mem[addr];
  end
endmodule
